// File: rtl/mytimer_irq_master_if.sv
// rtl/mytimer_irq_master_if.sv - chip-select/read/write bus between irq master and timer peripheral
interface mytimer_irq_master_if #(
    parameter int DATA_W = 32
);
    logic              m_cs_n;
    logic              m_read;
    logic [DATA_W-1:0] m_readdata;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;

    modport master (
        output m_cs_n,
        output m_read,
        input  m_readdata,
        output m_write,
        output m_writedata
    );

    modport slave (
        input  m_cs_n,
        input  m_read,
        output m_readdata,
        input  m_write,
        input  m_writedata
    );
endinterface

// File: rtl/mytimer_irq_master.sv
// rtl/mytimer_irq_master.sv - services timer irq: read word, ack write, one-entry valid/ready output
module mytimer_irq_master #(
    parameter int                DATA_W       = 32,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] ACK_DATA     = '0,
    parameter int                CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  irq,
    mytimer_irq_master_if.master  bus,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      overrun_count,
    output logic                  busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_ACK,
        S_GUARD
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       capture;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            S_IDLE:  if (enable && irq) state_next = S_READ;
            S_READ:  state_next = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = S_ACK;
                    capture    = 1'b1;
                end
            end
            S_ACK:   state_next = S_GUARD;
            S_GUARD: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes and busy are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            wait_cnt        <= 4'd0;
            bus.m_cs_n      <= 1'b1;
            bus.m_read      <= 1'b0;
            bus.m_write     <= 1'b0;
            bus.m_writedata <= '0;
            out_data        <= '0;
            out_valid       <= 1'b0;
            overrun_count   <= '0;
            busy            <= 1'b0;
        end else begin
            state           <= state_next;
            bus.m_read      <= (state_next == S_READ);
            bus.m_write     <= (state_next == S_ACK);
            bus.m_cs_n      <= !((state_next == S_READ) || (state_next == S_ACK));
            bus.m_writedata <= (state_next == S_ACK) ? ACK_DATA : '0;
            busy            <= (state_next != S_IDLE);

            if (state == S_READ) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            // A consume on the capture edge frees the slot for the incoming word.
            if (capture) begin
                if (!out_valid || out_ready) begin
                    out_data  <= bus.m_readdata;
                    out_valid <= 1'b1;
                end else if (overrun_count != {CNT_W{1'b1}}) begin
                    overrun_count <= overrun_count + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mytimer_irq_master.sv
// tb/tb_mytimer_irq_master.sv - directed bench for mytimer_irq_master
module tb_mytimer_irq_master;
    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          irq;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] overrun_count;
    logic          busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mytimer_irq_master_if #(.DATA_W(DW)) bus ();

    mytimer_irq_master #(
        .DATA_W(DW),
        .READ_LATENCY(1),
        .ACK_DATA(32'h0),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .irq(irq),
        .bus(bus.master),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun_count(overrun_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One L=1 service sequence starting from IDLE; irq is dropped during ACK.
    task automatic do_event(input logic [DW-1:0] d);
        irq = 1'b1;
        bus.m_readdata = d;
        tick();
        chk("ev_read", 64'(bus.m_read), 64'd1);
        tick();
        tick();
        chk("ev_ack", 64'(bus.m_write), 64'd1);
        irq = 1'b0;
        tick();
        tick();
        chk("ev_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b1;
        irq = 1'b0;
        out_ready = 1'b0;
        bus.m_readdata = '0;
        repeat (3) tick();
        chk("rst_cs_n", 64'(bus.m_cs_n), 64'd1);
        chk("rst_read", 64'(bus.m_read), 64'd0);
        chk("rst_write", 64'(bus.m_write), 64'd0);
        chk("rst_wdata", 64'(bus.m_writedata), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_overrun", 64'(overrun_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("quiet_cs_n", 64'(bus.m_cs_n), 64'd1);
            chk("quiet_busy", 64'(busy), 64'd0);
        end
        chk("quiet_valid", 64'(out_valid), 64'd0);
        chk("quiet_overrun", 64'(overrun_count), 64'd0);

        // Basic sequence with consumer always ready
        out_ready = 1'b1;
        irq = 1'b1;
        bus.m_readdata = 32'hDEADBEEF;
        tick();
        chk("t2_read", 64'(bus.m_read), 64'd1);
        chk("t2_read_cs", 64'(bus.m_cs_n), 64'd0);
        chk("t2_read_nowrite", 64'(bus.m_write), 64'd0);
        tick();
        chk("t2_wait_read", 64'(bus.m_read), 64'd0);
        chk("t2_wait_cs", 64'(bus.m_cs_n), 64'd1);
        chk("t2_wait_busy", 64'(busy), 64'd1);
        chk("t2_wait_valid", 64'(out_valid), 64'd0);
        tick();
        chk("t2_ack_write", 64'(bus.m_write), 64'd1);
        chk("t2_ack_cs", 64'(bus.m_cs_n), 64'd0);
        chk("t2_ack_wdata", 64'(bus.m_writedata), 64'd0);
        chk("t2_ack_noread", 64'(bus.m_read), 64'd0);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_data", 64'(out_data), 64'hDEADBEEF);
        irq = 1'b0;
        tick();
        chk("t2_guard_write", 64'(bus.m_write), 64'd0);
        chk("t2_guard_busy", 64'(busy), 64'd1);
        chk("t2_consumed", 64'(out_valid), 64'd0);
        tick();
        chk("t2_idle_busy", 64'(busy), 64'd0);
        tick();
        chk("t2_no_reread", 64'(bus.m_read), 64'd0);

        // Overrun: slot full, consumer stalled
        out_ready = 1'b0;
        do_event(32'd1);
        do_event(32'd2);
        do_event(32'd3);
        chk("ovr_data", 64'(out_data), 64'd1);
        chk("ovr_valid", 64'(out_valid), 64'd1);
        chk("ovr_count", 64'(overrun_count), 64'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ovr_drain", 64'(out_valid), 64'd0);

        // Capture and consume on the same edge
        do_event(32'd4);
        chk("cc_pre_data", 64'(out_data), 64'd4);
        irq = 1'b1;
        bus.m_readdata = 32'd5;
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        irq = 1'b0;
        chk("cc_data", 64'(out_data), 64'd5);
        chk("cc_valid", 64'(out_valid), 64'd1);
        chk("cc_overrun", 64'(overrun_count), 64'd2);
        tick();
        tick();
        chk("cc_hold_valid", 64'(out_valid), 64'd1);

        // Enable drops mid-sequence; the slot is full so this word overruns (count 3 = saturated)
        irq = 1'b1;
        bus.m_readdata = 32'd6;
        tick();
        tick();
        enable = 1'b0;
        tick();
        chk("en_ack_write", 64'(bus.m_write), 64'd1);
        chk("en_overrun", 64'(overrun_count), 64'd3);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("en_off_noread", 64'(bus.m_read), 64'd0);
            chk("en_off_busy", 64'(busy), 64'd0);
        end
        enable = 1'b1;
        tick();
        chk("en_on_read", 64'(bus.m_read), 64'd1);
        tick();
        tick();
        chk("rs_ack_write", 64'(bus.m_write), 64'd1);
        chk("sat_overrun", 64'(overrun_count), 64'd3);
        chk("rs_pre_valid", 64'(out_valid), 64'd1);

        // Reset pulse during ACK
        reset_n = 1'b0;
        irq = 1'b0;
        tick();
        chk("rs_write", 64'(bus.m_write), 64'd0);
        chk("rs_cs_n", 64'(bus.m_cs_n), 64'd1);
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_overrun", 64'(overrun_count), 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rs_after_write", 64'(bus.m_write), 64'd0);
        chk("rs_after_busy", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mytimer_irq_master.md
# mytimer_irq_master

Bus-master companion to the timer peripheral: sits on the initiator side of the peripheral's chip-select/read/write slave port and services its interrupt. On a pending `irq` it reads the peripheral's data word, acknowledges the interrupt with a write, and presents the captured word on a one-entry valid/ready output. Downstream logic gets a stream of timer events without a CPU in the loop.

## Interface
- `DATA_W`, 32, width of the slave data bus and of `out_data`
- `READ_LATENCY`, 1, cycles from the `m_read` cycle to valid `m_readdata`; legal range 1..15
- `ACK_DATA`, 32'h0, value driven on `m_writedata` during the acknowledge write
- `CNT_W`, 16, width of `overrun_count`

- `clk`  in  1  single clock; all logic rising-edge
- `reset_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  1 = service interrupts; 0 = no new transactions start
- `irq`  in  1  level interrupt from the peripheral
- `m_cs_n`  out  1  chip select to the peripheral, active-low
- `m_read`  out  1  read strobe
- `m_readdata`  in  DATA_W  read data from the peripheral
- `m_write`  out  1  write strobe
- `m_writedata`  out  DATA_W  write data; `ACK_DATA` during ACK, 0 otherwise
- `out_data`  out  DATA_W  captured word
- `out_valid`  out  1  `out_data` holds an unconsumed word
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` & `out_ready`
- `overrun_count`  out  CNT_W  words dropped because the output slot was full; saturating
- `busy`  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, READ, WAIT, ACK, GUARD.
- IDLE: if `enable` & `irq` at the edge, go to READ; otherwise stay.
- READ: one cycle; `m_cs_n`=0, `m_read`=1. Go to WAIT.
- WAIT: exactly `READ_LATENCY` cycles, strobes inactive. On the last WAIT cycle, sample `m_readdata` (capture). Go to ACK.
- ACK: one cycle; `m_cs_n`=0, `m_write`=1, `m_writedata`=`ACK_DATA`. Go to GUARD.
- GUARD: one idle cycle so that `irq` reflects the clear before IDLE re-samples it. Go to IDLE.
- `m_read` and `m_write` are never high together. `m_cs_n`=1 whenever neither strobe is high.
- Capture rule:
  - If the slot is empty, or `out_valid` & `out_ready` in the capture cycle: load `out_data` and set `out_valid`=1.
  - Otherwise the word is dropped, `out_data` is unchanged, and `overrun_count` increments. It saturates at all-ones.
- `out_valid` clears on the edge of `out_valid` & `out_ready`, unless a capture loads the slot on the same edge.
- `out_data` is stable while `out_valid`=1 and not consumed.
- If `enable` falls mid-sequence, the sequence still completes through GUARD; the FSM then waits in IDLE.
- `irq` is level-sensitive and sampled only in IDLE. If `irq` is still high in IDLE after GUARD (a new event arrived), a new sequence starts.
- `busy` = (state != IDLE).

## Timing
- Reset (`reset_n`=0 at an edge): state=IDLE, `m_cs_n`=1, `m_read`=0, `m_write`=0, `m_writedata`=0, `out_data`=0, `out_valid`=0, `overrun_count`=0, `busy`=0.
  - Reset mid-sequence abandons the transaction; no strobe is asserted after that edge.
- Let cycle t be the IDLE cycle where `enable` & `irq` is sampled high, and L = `READ_LATENCY`.
  - READ in t+1.
  - WAIT in t+2..t+1+L; capture at the end of t+1+L.
  - ACK in t+2+L, with `out_valid` first high in t+2+L.
  - GUARD in t+3+L; IDLE in t+4+L.
- Sequence length: L+3 cycles. Minimum spacing between READ strobes: L+4 cycles.
- All outputs are registered. There is no combinational path from `out_ready` or `irq` to any output.

## Test plan
- Reset, then hold `irq`=0 for 20 cycles -> `m_cs_n`=1 throughout, `out_valid`=0, `busy`=0, `overrun_count`=0.
- L=1; `irq` goes high at cycle 10, `m_readdata`=32'hDEADBEEF, `out_ready`=1; model clears `irq` after ACK.
  - Required: `m_read` in cycle 11, `m_write` with `m_writedata`=0 in cycle 13.
  - Required: `out_valid` high in cycle 13 with `out_data`=32'hDEADBEEF.
  - Required: `busy` low from cycle 15.
- `out_ready`=0; three irq events carrying 1, 2, 3 -> `out_data`=1 held, `overrun_count`=2.
  - Then raise `out_ready` for one cycle -> `out_valid`=0.
- Capture and consume on the same edge (`out_valid`=1, `out_ready`=1, new word 5) -> `out_data`=5, `out_valid` stays 1, no overrun.
- Drop `enable` during WAIT -> ACK still issued; with `irq` re-asserted while `enable`=0, no further `m_read`.
  - Re-enable -> READ occurs the cycle after `enable` is sampled high.
- Pulse `reset_n`=0 during ACK -> next cycle `m_write`=0, `m_cs_n`=1, `out_valid`=0, state IDLE.
